// File: rtl/cpu_run_ctrl_if.sv
// Run-control bus between a host/bench and cpu_run_ctrl: run requests,
// the core's store bus, core clock gating and the run results.
interface cpu_run_ctrl_if #(
  parameter int CNT_W       = 16,
  parameter int STORE_CNT_W = 16
);
  logic                   start;
  logic                   step_mode;
  logic                   step;
  logic                   mem_we;
  logic [31:0]            mem_addr;
  logic [31:0]            mem_data;
  logic [2:0]             mem_size;
  logic                   core_reset;
  logic                   core_en;
  logic                   done;
  logic                   timeout;
  logic                   pass;
  logic [31:0]            exit_code;
  logic [CNT_W-1:0]       cycle_count;
  logic [STORE_CNT_W-1:0] store_count;

  modport master (
    output start, step_mode, step, mem_we, mem_addr, mem_data, mem_size,
    input  core_reset, core_en, done, timeout, pass, exit_code,
           cycle_count, store_count
  );

  modport slave (
    input  start, step_mode, step, mem_we, mem_addr, mem_data, mem_size,
    output core_reset, core_en, done, timeout, pass, exit_code,
           cycle_count, store_count
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run controller and store monitor: holds the core in reset, runs it free or
// single-step, ends the run on a halt store or cycle timeout, reports results.
module cpu_run_ctrl #(
  parameter int          RESET_CYCLES = 1,
  parameter int          MAX_CYCLES   = 100,
  parameter int          CNT_W        = 16,
  parameter int          STORE_CNT_W  = 16,
  parameter logic [31:0] HALT_ADDR    = 32'h0000_0FFC,
  parameter logic [31:0] PASS_VALUE   = 32'h0000_0001
) (
  input logic           clk,
  input logic           reset,
  cpu_run_ctrl_if.slave bus
);

  localparam int HOLD_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_RST_HOLD  = 3'd1;
  localparam logic [2:0] S_RUN       = 3'd2;
  localparam logic [2:0] S_STEP_WAIT = 3'd3;
  localparam logic [2:0] S_STEP_EXEC = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  logic [2:0]             state;
  logic [HOLD_W-1:0]      hold_cnt;
  logic                   step_mode_q;
  logic                   timeout_q;
  logic                   pass_q;
  logic [31:0]            exit_q;
  logic [CNT_W-1:0]       cyc_q;
  logic [STORE_CNT_W-1:0] st_q;

  logic exec, halt, store, tmo;

  // A core cycle is executed only while enabled and out of reset; stores
  // outside those cycles never reach the monitor.
  assign exec  = (state == S_RUN) || (state == S_STEP_EXEC);
  assign halt  = exec && bus.mem_we && (bus.mem_addr == HALT_ADDR) &&
                 (bus.mem_size == 3'b010);
  assign store = exec && bus.mem_we && !halt;
  assign tmo   = exec && !halt && (cyc_q == CNT_W'(MAX_CYCLES - 1));

  // Run sequencing, result capture and saturating counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      hold_cnt    <= '0;
      step_mode_q <= 1'b0;
      timeout_q   <= 1'b0;
      pass_q      <= 1'b0;
      exit_q      <= '0;
      cyc_q       <= '0;
      st_q        <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            state       <= S_RST_HOLD;
            step_mode_q <= bus.step_mode;
            hold_cnt    <= HOLD_W'(RESET_CYCLES - 1);
            timeout_q   <= 1'b0;
            pass_q      <= 1'b0;
            exit_q      <= '0;
            cyc_q       <= '0;
            st_q        <= '0;
          end
        end
        S_RST_HOLD: begin
          if (hold_cnt == '0) state <= step_mode_q ? S_STEP_WAIT : S_RUN;
          else                hold_cnt <= hold_cnt - 1'b1;
        end
        S_RUN, S_STEP_EXEC: begin
          if (halt) begin
            state  <= S_DONE;
            exit_q <= bus.mem_data;
            pass_q <= (bus.mem_data == PASS_VALUE);
          end else if (tmo) begin
            state     <= S_DONE;
            timeout_q <= 1'b1;
          end else if (state == S_STEP_EXEC) begin
            state <= S_STEP_WAIT;
          end
        end
        S_STEP_WAIT: begin
          if (bus.step) state <= S_STEP_EXEC;
        end
        default: state <= S_IDLE;
      endcase

      // Counters only move on executed cycles, which never coincide with
      // the clear-on-start above.
      if (exec && (cyc_q != '1)) cyc_q <= cyc_q + 1'b1;
      if (store && (st_q != '1)) st_q  <= st_q + 1'b1;
    end
  end

  // Moore decode of the core controls from the state register.
  assign bus.core_reset  = (state == S_IDLE) || (state == S_RST_HOLD);
  assign bus.core_en     = (state == S_RST_HOLD) || exec;
  assign bus.done        = (state == S_DONE);
  assign bus.timeout     = timeout_q;
  assign bus.pass        = pass_q;
  assign bus.exit_code   = exit_q;
  assign bus.cycle_count = cyc_q;
  assign bus.store_count = st_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: three instances cover the default
// configuration, a 3-cycle reset hold in step mode, and a 4-cycle timeout.
module tb_cpu_run_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   vectors = 0;
  int   miscompares = 0;
  int   n, hold, run;

  always #5 clk = ~clk;

  cpu_run_ctrl_if ifa ();
  cpu_run_ctrl_if ifb ();
  cpu_run_ctrl_if ifc ();

  cpu_run_ctrl dut_a (.clk(clk), .reset(rst), .bus(ifa));
  cpu_run_ctrl #(.RESET_CYCLES(3)) dut_b (.clk(clk), .reset(rst), .bus(ifb));
  cpu_run_ctrl #(.MAX_CYCLES(4))   dut_c (.clk(clk), .reset(rst), .bus(ifc));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    ifa.start = 0; ifa.step_mode = 0; ifa.step = 0; ifa.mem_we = 0;
    ifa.mem_addr = 0; ifa.mem_data = 0; ifa.mem_size = 3'b010;
    ifb.start = 0; ifb.step_mode = 0; ifb.step = 0; ifb.mem_we = 0;
    ifb.mem_addr = 0; ifb.mem_data = 0; ifb.mem_size = 3'b010;
    ifc.start = 0; ifc.step_mode = 0; ifc.step = 0; ifc.mem_we = 0;
    ifc.mem_addr = 0; ifc.mem_data = 0; ifc.mem_size = 3'b010;
    tick; tick;

    // reset state
    chk("rst core_reset", ifa.core_reset, 1);
    chk("rst core_en", ifa.core_en, 0);
    chk("rst done", ifa.done, 0);
    chk("rst timeout", ifa.timeout, 0);
    chk("rst pass", ifa.pass, 0);
    chk("rst exit", ifa.exit_code, 0);
    chk("rst cyc", ifa.cycle_count, 0);
    chk("rst st", ifa.store_count, 0);
    rst = 1'b0;
    tick;

    // free-run timeout
    ifa.start = 1; tick; ifa.start = 0;
    hold = 0; run = 0;
    for (int k = 0; k < 200 && !ifa.done; k++) begin
      if (ifa.core_en && ifa.core_reset) hold++;
      if (ifa.core_en && !ifa.core_reset) run++;
      tick;
    end
    chk("t1 hold", hold, 1);
    chk("t1 run", run, 100);
    chk("t1 done", ifa.done, 1);
    chk("t1 timeout", ifa.timeout, 1);
    chk("t1 pass", ifa.pass, 0);
    chk("t1 cyc", ifa.cycle_count, 100);
    chk("t1 st", ifa.store_count, 0);

    // halt pass on executed cycle 10 after three ordinary stores
    ifa.start = 1; tick; ifa.start = 0;
    n = 0;
    for (int k = 0; k < 200 && !ifa.done; k++) begin
      ifa.mem_we = 0; ifa.mem_addr = 0; ifa.mem_data = 0; ifa.mem_size = 3'b010;
      if (ifa.core_en && !ifa.core_reset) begin
        n++;
        if (n == 2 || n == 4 || n == 6) begin
          ifa.mem_we = 1; ifa.mem_addr = 32'h100; ifa.mem_data = n;
        end else if (n == 10) begin
          ifa.mem_we = 1; ifa.mem_addr = 32'h0FFC; ifa.mem_data = 32'h1;
        end
      end
      tick;
    end
    ifa.mem_we = 0;
    chk("t2 done", ifa.done, 1);
    chk("t2 pass", ifa.pass, 1);
    chk("t2 exit", ifa.exit_code, 32'h1);
    chk("t2 cyc", ifa.cycle_count, 10);
    chk("t2 st", ifa.store_count, 3);
    chk("t2 core_en", ifa.core_en, 0);
    chk("t2 timeout", ifa.timeout, 0);

    // size filter, stores during reset hold ignored, halt with fail data
    ifa.start = 1; tick; ifa.start = 0;
    n = 0;
    for (int k = 0; k < 200 && !ifa.done; k++) begin
      ifa.mem_we = 0; ifa.mem_addr = 0; ifa.mem_data = 0; ifa.mem_size = 3'b010;
      if (ifa.core_en && ifa.core_reset) begin
        ifa.mem_we = 1; ifa.mem_addr = 32'h100;
      end else if (ifa.core_en) begin
        n++;
        if (n == 3) begin
          ifa.mem_we = 1; ifa.mem_addr = 32'h0FFC; ifa.mem_data = 32'h1;
          ifa.mem_size = 3'b000;
        end else if (n == 5) begin
          ifa.mem_we = 1; ifa.mem_addr = 32'h0FFC; ifa.mem_data = 32'hDEAD;
        end
      end
      tick;
    end
    ifa.mem_we = 0; ifa.mem_size = 3'b010;
    chk("t3 done", ifa.done, 1);
    chk("t3 st", ifa.store_count, 1);
    chk("t3 pass", ifa.pass, 0);
    chk("t3 exit", ifa.exit_code, 32'hDEAD);
    chk("t3 cyc", ifa.cycle_count, 5);

    // step mode, 3-cycle reset hold
    ifb.start = 1; ifb.step_mode = 1; tick; ifb.start = 0; ifb.step_mode = 0;
    hold = 0; run = 0;
    for (int k = 0; k < 6; k++) begin
      if (ifb.core_en && ifb.core_reset) hold++;
      if (ifb.core_en && !ifb.core_reset) run++;
      tick;
    end
    chk("t4 hold", hold, 3);
    chk("t4 idle en", run, 0);
    chk("t4 wait reset", ifb.core_reset, 0);
    for (int i = 0; i < 20; i++) begin
      if (ifb.core_en) run++;
      ifb.step = (i % 4 == 0) || (i == 5);
      tick;
    end
    ifb.step = 0;
    chk("t4 steps", run, 5);
    chk("t4 cyc", ifb.cycle_count, 5);
    chk("t4 done", ifb.done, 0);
    chk("t4 core_en", ifb.core_en, 0);

    // halt coinciding with timeout (MAX_CYCLES=4)
    ifc.start = 1; tick; ifc.start = 0;
    n = 0;
    for (int k = 0; k < 50 && !ifc.done; k++) begin
      ifc.mem_we = 0;
      if (ifc.core_en && !ifc.core_reset) begin
        n++;
        if (n == 4) begin
          ifc.mem_we = 1; ifc.mem_addr = 32'h0FFC; ifc.mem_data = 32'h1;
        end
      end
      tick;
    end
    ifc.mem_we = 0;
    chk("t5 done", ifc.done, 1);
    chk("t5 timeout", ifc.timeout, 0);
    chk("t5 pass", ifc.pass, 1);
    chk("t5 cyc", ifc.cycle_count, 4);
    ifc.start = 1; tick; ifc.start = 0;
    for (int k = 0; k < 50 && !ifc.done; k++) tick;
    chk("t5b timeout", ifc.timeout, 1);
    chk("t5b cyc", ifc.cycle_count, 4);
    chk("t5b pass", ifc.pass, 0);

    // reset mid-run at executed cycle 50; start in RUN must be ignored
    ifa.start = 1; tick; ifa.start = 0;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      ifa.mem_we = 0; ifa.start = 0;
      if (ifa.core_en && !ifa.core_reset) begin
        n++;
        if (n == 10 || n == 11) begin
          ifa.mem_we = 1; ifa.mem_addr = 32'h200;
        end
        if (n == 20) ifa.start = 1;
        if (n == 50) begin
          chk("t6 cyc before rst", ifa.cycle_count, 49);
          chk("t6 st before rst", ifa.store_count, 2);
          rst = 1;
          tick;
          break;
        end
      end
      tick;
    end
    ifa.mem_we = 0; ifa.start = 0;
    chk("t6 core_reset", ifa.core_reset, 1);
    chk("t6 core_en", ifa.core_en, 0);
    chk("t6 done", ifa.done, 0);
    chk("t6 cyc", ifa.cycle_count, 0);
    chk("t6 st", ifa.store_count, 0);
    rst = 0;
    tick;
    ifa.start = 1; tick; ifa.start = 0;
    hold = 0; run = 0;
    for (int k = 0; k < 200 && !ifa.done; k++) begin
      if (ifa.core_en && ifa.core_reset) hold++;
      if (ifa.core_en && !ifa.core_reset) run++;
      tick;
    end
    chk("t6 rerun hold", hold, 1);
    chk("t6 rerun run", run, 100);
    chk("t6 rerun timeout", ifa.timeout, 1);
    chk("t6 rerun cyc", ifa.cycle_count, 100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Synthesisable run controller and store monitor for the CPU core, the parametrised successor to a fixed clock/reset test harness. Holds the core in reset for a programmable number of cycles, then runs it free or single-step with a clock enable. Watches the core's data-memory store bus for a halt store and bounds the run with a cycle timeout. Reports done, pass/fail, exit code and cycle and store counts to the bench or a debug host.

Parameters:
RESET_CYCLES, 1, enabled cycles core_reset is held after start (>=1)
MAX_CYCLES, 100, executed cycles before timeout (>=1, < 2**CNT_W)
CNT_W, 16, width of cycle_count
STORE_CNT_W, 16, width of store_count
HALT_ADDR, 32'h0000_0FFC, store address that ends the run
PASS_VALUE, 32'h0000_0001, halt data value meaning pass

Ports:
clk  in  1  single clock
reset  in  1  synchronous, active-high
start  in  1  begin run; accepted only in IDLE or DONE
step_mode  in  1  sampled with start: 0 free-run, 1 single-step
step  in  1  one-cycle pulse: execute one core cycle (step mode only)
mem_we  in  1  core store strobe
mem_addr  in  32  core data-memory address
mem_data  in  32  core store data
mem_size  in  3  core store size (3'b010 = word)
core_reset  out  1  reset to core
core_en  out  1  clock enable to core
done  out  1  run finished
timeout  out  1  run ended by MAX_CYCLES
pass  out  1  halt data == PASS_VALUE
exit_code  out  32  data of halt store
cycle_count  out  CNT_W  executed cycles, saturating
store_count  out  STORE_CNT_W  non-halt stores, saturating

Behaviour:
- States: IDLE, RST_HOLD, RUN, STEP_WAIT, STEP_EXEC, DONE. core_reset and core_en are Moore outputs decoded from the state register. No input-to-output combinational path.
- Reset (synchronous, overrides everything including mid-run): state IDLE. core_reset=1, core_en=0, done=0, timeout=0, pass=0, exit_code=0, cycle_count=0, store_count=0.
- IDLE: core_reset=1, core_en=0. start=1 -> RST_HOLD. Latch step_mode. Load hold counter with RESET_CYCLES-1. Clear done, timeout, pass, exit_code and both counts.
- RST_HOLD: core_reset=1, core_en=1 so the core sees reset edges. Decrement the hold counter. At 0, go to RUN (step_mode=0) or STEP_WAIT (step_mode=1).
- RUN: core_reset=0, core_en=1. This is an executed cycle.
- STEP_WAIT: core_reset=0, core_en=0. step=1 -> STEP_EXEC.
- STEP_EXEC: core_en=1 for exactly one cycle (an executed cycle), then -> STEP_WAIT. A step pulse arriving in STEP_EXEC is ignored.
- On each executed cycle:
  - cycle_count increments.
  - Halt: mem_we=1, mem_addr==HALT_ADDR and mem_size==3'b010 -> DONE. Capture exit_code=mem_data and pass=(mem_data==PASS_VALUE). A halt store does not increment store_count.
  - Any other mem_we=1 -> store_count increments, saturating at all-ones.
  - Timeout: no halt and cycle_count==MAX_CYCLES-1 before the increment -> DONE with timeout=1, pass=0.
- Halt and timeout in the same cycle: halt wins, timeout=0.
- Stores while core_en=0 or core_reset=1 are ignored.
- A non-word store to HALT_ADDR counts as an ordinary store.
- DONE: core_reset=0, core_en=0, done=1. All results hold. start -> RST_HOLD (rerun; results cleared as from IDLE).
- start outside IDLE/DONE is ignored. step outside STEP_WAIT is ignored.

Test Plan:
- Free-run timeout: defaults, start at cycle 0, no stores.
  - -> core_reset=1 for 1 enabled cycle, then core_en=1 for exactly 100 cycles.
  - -> done=1, timeout=1, pass=0, cycle_count=100.
- Halt pass: store word 32'h1 to 32'h0FFC on the 10th executed cycle, with 3 earlier stores to 32'h100.
  - -> done=1, pass=1, exit_code=1, cycle_count=10, store_count=3, core_en=0 the next cycle.
- Halt fail and size filter: a byte store (mem_size=3'b000) to 32'h0FFC, then a word store of 32'hDEAD.
  - -> the byte store counts as store_count=1.
  - -> halt on the word store: pass=0, exit_code=32'hDEAD.
- Step mode with RESET_CYCLES=3: core_reset held 3 cycles, core_en stays 0 until step.
  - 5 step pulses spaced 4 cycles -> exactly 5 single core_en cycles, cycle_count=5.
  - A step pulse during STEP_EXEC is ignored.
- Simultaneous halt and timeout: MAX_CYCLES=4, halt store on executed cycle 4.
  - -> timeout=0, done=1, pass per data.
- Reset mid-run at executed cycle 50.
  - -> next cycle: IDLE, core_reset=1, all results 0.
  - A new start runs cleanly to timeout at 100.
